// File: rtl/huffman_ctrl_pkg.sv
// Shared types and widths for the Huffman encoder block sequencer.
package huffman_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ENC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/huffman_out_capture.sv
// Captures encoder output words into a valid/ready register; tracks overflow
// and a saturating per-block word count.
module huffman_out_capture
  import huffman_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             clear,
  input  logic             word_rdy,
  input  logic [ENC_W-1:0] word_in,
  output logic             m_valid,
  output logic [ENC_W-1:0] m_data,
  input  logic             m_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count
);

  logic take;

  assign take = capture_en && word_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (take) begin
        m_data  <= word_in;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      // clear only fires from IDLE, where capture is disabled
      if (clear) begin
        overflow   <= 1'b0;
        word_count <= '0;
      end else if (take) begin
        if (m_valid && !m_ready) overflow <= 1'b1;
        if (word_count != '1) word_count <= word_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/huffman_block_ctrl.sv
// Block sequencer for the 8-in/16-out Huffman encoder.
// Optional HUFF_CTRL_STATS_EN adds a block_cycles counter port.
module huffman_block_ctrl
  import huffman_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_LEN    = 8,
  parameter int unsigned DRAIN_CYCLES = 12,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              enc_enable,
  output logic              enc_in_enable,
  output logic [BYTE_W-1:0] enc_data,
  input  logic              enc_out_rdy,
  input  logic [ENC_W-1:0]  enc_data_out,
  output logic              m_valid,
  output logic [ENC_W-1:0]  m_data,
  input  logic              m_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_count
`ifdef HUFF_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  block_cycles
`endif
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept, start_go, last_byte, drain_done, capture_en;

  assign accept     = s_valid && s_ready;
  assign start_go   = (state_q == ST_IDLE) && start && !abort;
  assign last_byte  = (byte_cnt == CNT_W'(BLOCK_LEN - 1));
  assign drain_done = !enc_out_rdy && (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    s_ready    = 1'b0;
    enc_enable = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE: if (start_go) state_d = ST_PRIME;
      ST_PRIME: begin
        enc_enable = 1'b1;
        capture_en = 1'b1;
        state_d    = ST_FEED;
      end
      ST_FEED: begin
        enc_enable = 1'b1;
        capture_en = 1'b1;
        s_ready    = 1'b1;
        if (accept && last_byte) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        enc_enable = 1'b1;
        capture_en = 1'b1;
        if (drain_done) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // enc_data/enc_in_enable are registered: one-cycle latency to the encoder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt      <= '0;
      drain_cnt     <= '0;
      enc_data      <= '0;
      enc_in_enable <= 1'b0;
    end else begin
      enc_in_enable <= 1'b0;
      if (abort || (state_q == ST_IDLE)) begin
        byte_cnt  <= '0;
        drain_cnt <= '0;
      end else begin
        if ((state_q == ST_FEED) && accept) begin
          enc_data      <= s_data;
          enc_in_enable <= 1'b1;
          byte_cnt      <= last_byte ? '0 : byte_cnt + 1'b1;
        end
        if (state_q == ST_DRAIN) begin
          if (enc_out_rdy || drain_done) drain_cnt <= '0;
          else                           drain_cnt <= drain_cnt + 1'b1;
        end
      end
    end
  end

`ifdef HUFF_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                block_cycles <= '0;
    else if (start_go)                                      block_cycles <= '0;
    else if ((state_q != ST_IDLE) && (block_cycles != '1)) block_cycles <= block_cycles + 1'b1;
  end
`endif

  huffman_out_capture #(
    .CNT_W(CNT_W)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .clear      (start_go),
    .word_rdy   (enc_out_rdy),
    .word_in    (enc_data_out),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .overflow   (overflow),
    .word_count (word_count)
  );

endmodule

// File: tb/tb_huffman_block_ctrl.sv
// Self-checking bench for huffman_block_ctrl: table-driven FEED vectors,
// scoreboard on the captured-word stream, hand-written corner sequences.
`timescale 1ns/1ps
module tb_huffman_block_ctrl;

  localparam int unsigned BLOCK_LEN    = 8;
  localparam int unsigned DRAIN_CYCLES = 12;
  localparam int unsigned CNT_W        = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0, enc_out_rdy = 1'b0, m_ready = 1'b0;
  logic [7:0]  s_data = '0;
  logic [15:0] enc_data_out = '0;
  logic busy, done, s_ready, enc_enable, enc_in_enable, m_valid, overflow;
  logic [7:0]  enc_data;
  logic [15:0] m_data;
  logic [CNT_W-1:0] word_count;
`ifdef HUFF_CTRL_STATS_EN
  logic [CNT_W-1:0] block_cycles;
`endif

  always #5 clk = ~clk;

  huffman_block_ctrl #(
    .BLOCK_LEN   (BLOCK_LEN),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .enc_enable   (enc_enable),
    .enc_in_enable(enc_in_enable),
    .enc_data     (enc_data),
    .enc_out_rdy  (enc_out_rdy),
    .enc_data_out (enc_data_out),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .overflow     (overflow),
    .word_count   (word_count)
`ifdef HUFF_CTRL_STATS_EN
    ,
    .block_cycles (block_cycles)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       exp_ien;
    logic [7:0] exp_data;
  } vec_t;

  vec_t        vecs [20];
  logic [7:0]  blk_bytes [8];
  logic [15:0] sbq [$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned done_seen = 0;
  bit          sb_on = 1'b0;
  bit          auto_enc = 1'b0;

  function automatic logic [15:0] enc_word(input logic [7:0] b);
    return {~b, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: score the handshake pending at this edge, advance, then let
  // the encoder model answer the byte it was just handed.
  task automatic tick();
    logic [15:0] e;
    if (sb_on && m_valid && m_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_word: got 0x%0h expected no word", m_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_m_data", 32'(m_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (auto_enc) begin
      enc_out_rdy  = enc_in_enable;
      enc_data_out = enc_word(enc_data);
    end
    if (done) done_seen++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i * 3 + 1);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      s_valid = vecs[i].v;
      s_data  = vecs[i].d;
      if (vecs[i].v && sb_on) sbq.push_back(enc_word(vecs[i].d));
      tick();
      chk($sformatf("row%0d_ien", i), 32'(enc_in_enable), 32'(vecs[i].exp_ien));
      chk($sformatf("row%0d_data", i), 32'(enc_data), 32'(vecs[i].exp_data));
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned exp_n);
    int unsigned n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 32'({busy, done, s_ready, enc_enable, enc_in_enable, m_valid, overflow}), 32'h0);
    chk({name, "_data"}, 32'({enc_data, m_data}), 32'h0);
    chk({name, "_wc"}, 32'(word_count), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int unsigned d0;
    blk_bytes = '{8'd5, 8'd68, 8'd50, 8'd100, 8'd150, 8'd200, 8'd250, 8'd255};
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, blk_bytes[i], 1'b1, blk_bytes[i]};
    k = 8;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        for (int j = 0; j < 4; j++) begin
          vecs[k] = '{1'b0, 8'h00, 1'b0, blk_bytes[1]};
          k++;
        end
      end
      vecs[k] = '{1'b1, blk_bytes[i], 1'b1, blk_bytes[i]};
      k++;
    end

    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // happy path
    m_ready = 1'b1; sb_on = 1'b1; auto_enc = 1'b1;
    do_start();
    chk("prime_outs", 32'({busy, enc_enable, enc_in_enable, s_ready}), 32'b1100);
    tick();
    chk("feed_ready", 32'(s_ready), 32'd1);
    run_rows(0, 7);
    chk("drain_ready", 32'({busy, s_ready}), 32'b10);
    wait_done("happy_done_delay", DRAIN_CYCLES + 1);
    chk("happy_wc", 32'(word_count), 32'd8);
    chk("happy_ovf", 32'(overflow), 32'd0);
    tick();
    chk("happy_idle", 32'({busy, done}), 32'd0);
    chk("happy_sb_empty", 32'(sbq.size()), 32'd0);
`ifdef HUFF_CTRL_STATS_EN
    chk("block_cycles", 32'(block_cycles), 32'd23);
`endif

    // stall after byte 2
    do_start();
    tick();
    run_rows(8, 19);
    wait_done("stall_done_delay", DRAIN_CYCLES + 1);
    chk("stall_wc", 32'(word_count), 32'd8);
    tick();
    chk("stall_sb_empty", 32'(sbq.size()), 32'd0);

    // backpressure and overflow
    sb_on = 1'b0; auto_enc = 1'b0; m_ready = 1'b0;
    enc_out_rdy = 1'b1; enc_data_out = 16'h9999;
    tick();
    enc_out_rdy = 1'b0;
    chk("idle_word_ignored", 32'({m_valid, word_count}), 32'd8);
    do_start();
    chk("start_clears_wc", 32'(word_count), 32'd0);
    enc_out_rdy = 1'b1; enc_data_out = 16'h1234;
    tick();
    enc_data_out = 16'hABCD;
    tick();
    enc_out_rdy = 1'b0;
    chk("bp_m_data", 32'(m_data), 32'hABCD);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_wc", 32'(word_count), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("bp_abort_idle", 32'({busy, enc_enable, s_ready, done}), 32'd0);
    chk("bp_word_kept", 32'({m_valid, m_data, overflow}), {15'd0, 1'b1, 16'hABCD, 1'b1} >> 0);
    do_start();
    chk("start_clears_ovf", 32'(overflow), 32'd0);
    m_ready = 1'b1; enc_out_rdy = 1'b1; enc_data_out = 16'h0F0F;
    tick();
    enc_out_rdy = 1'b0;
    chk("take_same_cycle_no_ovf", 32'({overflow, m_data}), 32'h0_0F0F);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // drain extension
    do_start();
    tick();
    feed(BLOCK_LEN);
    repeat (10) tick();
    enc_out_rdy = 1'b1; enc_data_out = 16'h5555;
    tick();
    enc_out_rdy = 1'b0;
    wait_done("drain_ext_tail", DRAIN_CYCLES);
    chk("drain_ext_word", 32'({m_data, word_count}), {16'h5555, 16'd1});
    tick();

    // start ignored while busy, then abort in DRAIN
    do_start();
    tick();
    start = 1'b1;
    feed(3);
    start = 1'b0;
    feed(4);
    chk("seven_bytes_ready", 32'(s_ready), 32'd1);
    feed(1);
    chk("eight_bytes_drain", 32'({busy, s_ready}), 32'b10);
    tick();
    tick();
    d0 = done_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drain_idle", 32'({busy, enc_enable, enc_in_enable, s_ready, done}), 32'd0);
    repeat (DRAIN_CYCLES + 4) tick();
    chk("abort_no_done", done_seen - d0, 32'd0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", 32'(busy), 32'd0);

    // async reset mid-FEED
    m_ready = 1'b0; auto_enc = 1'b1;
    do_start();
    tick();
    feed(3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    auto_enc = 1'b0; enc_out_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({busy, overflow}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huffman_block_ctrl.md
Name: huffman_block_ctrl

Overview:
- Sequencer for the 8-bit-in / 16-bit-out Huffman encoder datapath.
- Frames an incoming byte stream (valid/ready) into blocks of BLOCK_LEN bytes.
- Drives the encoder's enable, in_enable and data_in, then waits for the encoder to drain.
- Captures each out_rdy word into a valid/ready output register and signals block completion.

Parameters:
- BLOCK_LEN, 8: bytes fed per block (>=1).
- DRAIN_CYCLES, 12: quiet cycles (no enc_out_rdy) after the last byte before the block counts as finished (>=1).
- CNT_W, 16: width of the byte, drain and word counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse; begins a block when idle, ignored otherwise.
- abort  in  1  synchronous abort; returns to IDLE.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at block end.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  byte accepted when s_valid&&s_ready.
- enc_enable  out  1  to encoder enable.
- enc_in_enable  out  1  to encoder in_enable.
- enc_data  out  8  to encoder data_in.
- enc_out_rdy  in  1  from encoder out_rdy.
- enc_data_out  in  16  from encoder data_out.
- m_valid  out  1  captured word valid.
- m_data  out  16  captured word.
- m_ready  in  1  consumer accepts word.
- overflow  out  1  sticky; a word was overwritten before it was taken.
- word_count  out  CNT_W  words captured in the current/last block.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0, all counters 0, overflow cleared.
- FSM states: IDLE, PRIME, FEED, DRAIN, FINISH.
- IDLE:
  - enc_enable=0, s_ready=0.
  - start=1 -> PRIME; word_count cleared on the same edge.
- PRIME (exactly one cycle):
  - enc_enable=1, enc_in_enable=0.
  - -> FEED. The encoder gets one enabled cycle before the first byte.
- FEED:
  - s_ready=1.
  - On accept: enc_data<=s_data, enc_in_enable<=1 (registered; one-cycle latency to the encoder), byte_cnt++.
  - No accept: enc_in_enable<=0 and enc_data holds (stall).
  - Accept when byte_cnt==BLOCK_LEN-1 -> DRAIN, byte_cnt<=0.
- DRAIN:
  - enc_enable=1, enc_in_enable=0, s_ready=0.
  - drain_cnt increments each cycle and resets to 0 on any enc_out_rdy.
  - drain_cnt==DRAIN_CYCLES-1 with no enc_out_rdy -> FINISH.
- FINISH (one cycle):
  - done=1, enc_enable<=0.
  - -> IDLE.
- Output capture (active in PRIME/FEED/DRAIN; enc_out_rdy ignored in IDLE/FINISH):
  - enc_out_rdy: m_data<=enc_data_out, m_valid<=1, word_count++.
  - m_valid&&m_ready with no new word: m_valid<=0.
  - New word while m_valid=1 and m_ready=0: overwrite, set overflow. Simultaneous m_ready=1 is not an overflow.
  - overflow is cleared only by rst or by start.
- abort:
  - Any non-IDLE state -> IDLE next edge; enc_enable, enc_in_enable and s_ready go to 0; no done pulse.
  - m_valid/m_data are kept for the consumer.
- start while busy: ignored.
- abort and start in the same cycle: abort wins.
- word_count saturates at all-ones.
- BLOCK_LEN=1: FEED accepts one byte, then DRAIN.

Optional Feature:
- Macro: HUFF_CTRL_STATS_EN.
- Defined: extra output port block_cycles [CNT_W-1:0].
  - Counts cycles from PRIME entry to FINISH inclusive.
  - Cleared on start; holds its value after FINISH; saturates.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package huffman_ctrl_pkg:
  - FSM state encoding (3-bit localparams).
  - Byte width 8, encoder output width 16.
- Sub-module huffman_out_capture:
  - Output register, m_valid/m_ready handshake, overflow and word_count logic.
  - Enabled by a capture_en input driven from the FSM.

Test Plan:
- Reset mid-FEED after 3 bytes: all outputs 0 immediately (async), FSM IDLE, overflow 0.
- Happy path:
  - Stimulus: start, then bytes 5,68,50,100,150,200,250,255 with continuous s_valid; encoder model returns one word per byte; m_ready=1.
  - Response: one PRIME cycle with enc_enable=1, enc_in_enable=0; 8 enc_in_enable pulses, each carrying the byte from the prior cycle; word_count=8; done pulse exactly DRAIN_CYCLES cycles after the last out_rdy; overflow=0.
- Stall: drop s_valid for 4 cycles after byte 2 -> enc_in_enable low for those 4 cycles, enc_data held at 68, block still ends with 8 bytes fed.
- Backpressure: m_ready=0 with two encoder words 0x1234 then 0xABCD -> m_data=0xABCD, overflow=1; a later start clears overflow.
- Drain extension: out_rdy arriving at drain_cnt=10 (DRAIN_CYCLES=12) -> drain_cnt resets, done is delayed by 11 cycles.
- Abort in DRAIN: next cycle IDLE, enc_enable=0, no done; start during FEED is ignored, with byte_cnt unaffected.
